mul_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit with HI/LO result registers, sitting directly downstream of the register file's `regA`/`regB` read ports. It executes MULT, MULTU, DIV and DIVU over multiple cycles through a start/busy/done handshake. HI/LO results feed the write-back path through `writeData`.

---
 rtl/mul_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO result registers and a start/busy/done handshake.
// Define MULDIV_DIVIDER_EN to build the restoring divider; without it DIV/DIVU finish at once with HI/LO untouched.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] regA,
  input  logic [31:0] regB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divZero
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opnd_q;
  logic        neg_q;
  logic        busy_q;
  logic        done_q;
  logic        divzero_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
`ifdef MULDIV_DIVIDER_EN
  logic        is_div_q;
  logic        neg_rem_q;
  logic [32:0] rem_sh_s;
`endif

  logic        signed_op_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [32:0] mul_sum_s;
  logic [63:0] acc_d;
  logic [63:0] prod_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;

  // Operand magnitudes; negation wraps, so 0x80000000 stays 0x80000000 as an unsigned magnitude
  always_comb begin
    signed_op_s = ~op[0];
    if (signed_op_s && regA[31]) begin
      a_mag_s = 32'd0 - regA;
    end else begin
      a_mag_s = regA;
    end
    if (signed_op_s && regB[31]) begin
      b_mag_s = 32'd0 - regB;
    end else begin
      b_mag_s = regB;
    end
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mul_sum_s = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    acc_d     = {mul_sum_s, acc_q[31:1]};
`ifdef MULDIV_DIVIDER_EN
    rem_sh_s  = acc_q[63:31];
    if (is_div_q) begin
      if (rem_sh_s >= {1'b0, opnd_q}) begin
        acc_d = {rem_sh_s[31:0] - opnd_q, acc_q[30:0], 1'b1};
      end else begin
        acc_d = {rem_sh_s[31:0], acc_q[30:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum_s, acc_q[31:1]};
    end
`endif
  end

  // Sign correction applied when the FINISH state commits HI/LO
  always_comb begin
    prod_s   = neg_q ? (64'd0 - acc_q) : acc_q;
    res_hi_s = prod_s[63:32];
    res_lo_s = prod_s[31:0];
`ifdef MULDIV_DIVIDER_EN
    if (is_div_q) begin
      res_lo_s = neg_q     ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
      res_hi_s = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end else begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end
`endif
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
`ifdef MULDIV_DIVIDER_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
`ifdef MULDIV_DIVIDER_EN
            if (op[1] && (regB == 32'd0)) begin
              done_q    <= 1'b1;
              divzero_q <= 1'b1;
            end else begin
              state_q   <= S_RUN;
              busy_q    <= 1'b1;
              divzero_q <= 1'b0;
              cnt_q     <= 5'd0;
              is_div_q  <= op[1];
              neg_q     <= signed_op_s & (regA[31] ^ regB[31]);
              neg_rem_q <= signed_op_s & regA[31];
              acc_q     <= {32'd0, (op[1] ? a_mag_s : b_mag_s)};
              opnd_q    <= op[1] ? b_mag_s : a_mag_s;
            end
`else
            if (op[1]) begin
              done_q    <= 1'b1;
              divzero_q <= 1'b0;
            end else begin
              state_q   <= S_RUN;
              busy_q    <= 1'b1;
              divzero_q <= 1'b0;
              cnt_q     <= 5'd0;
              neg_q     <= signed_op_s & (regA[31] ^ regB[31]);
              acc_q     <= {32'd0, b_mag_s};
              opnd_q    <= a_mag_s;
            end
`endif
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          hi_q    <= res_hi_s;
          lo_q    <= res_lo_s;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divZero = divzero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expectations queued at issue, compared on every done pulse.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] regA;
  logic [31:0] regB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divZero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks;
  int          n_errors;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  mul_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .regA    (regA),
    .regB    (regB),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .divZero (divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference results from native 64-bit arithmetic
  function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] prev);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = prev;
    case (o)
      2'b00: res = sa * sb;
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b != 32'd0) begin
          uq = a / b;
          ur = a % b;
          res = {ur, uq};
        end
      end
    endcase
    return res;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_value("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_value("hi", {32'd0, hi}, {32'd0, e.hi});
        check_value("lo", {32'd0, lo}, {32'd0, e.lo});
        check_value("divZero", {63'd0, divZero}, {63'd0, e.dz});
      end
    end
  end

  // Called at a negedge; drives one request and returns at the negedge where done is seen
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input int elat, input bit poke);
    int cycles;
    int nbusy;
    start = 1'b1;
    op    = o;
    regA  = a;
    regB  = b;
    sb_q.push_back('{hi: ehi, lo: elo, dz: edz});
    model_hi = ehi;
    model_lo = elo;
    @(negedge clk);
    start  = 1'b0;
    op     = 2'($urandom_range(3, 0));
    regA   = $urandom;
    regB   = $urandom;
    cycles = 0;
    nbusy  = busy ? 1 : 0;
    if (elat > 0) begin
      check_value("busy_after_start", {63'd0, busy}, 64'd1);
      check_value("dz_cleared", {63'd0, divZero}, 64'd0);
    end
    while (done !== 1'b1 && cycles < 60) begin
      start = (poke && cycles == 4) ? 1'b1 : 1'b0;
      if (start) begin
        op   = 2'b01;
        regA = 32'h1234_5678;
        regB = 32'h0000_0009;
      end
      @(negedge clk);
      cycles++;
      if (busy) nbusy++;
    end
    start = 1'b0;
    check_value("latency", 64'(cycles), 64'(elat));
    check_value("busy_cycles", 64'(nbusy), 64'(elat));
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [63:0] r;
    logic        dz;
    int          lat;
`ifdef MULDIV_DIVIDER_EN
    r   = model_res(o, a, b, {model_hi, model_lo});
    dz  = o[1] && (b == 32'd0);
    lat = dz ? 0 : 33;
`else
    if (o[1]) begin
      r   = {model_hi, model_lo};
      dz  = 1'b0;
      lat = 0;
    end else begin
      r   = model_res(o, a, b, {model_hi, model_lo});
      dz  = 1'b0;
      lat = 33;
    end
`endif
    run_op(o, a, b, r[63:32], r[31:0], dz, lat, poke);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    regA  = 32'd0;
    regB  = 32'd0;
    repeat (3) @(negedge clk);
    check_value("rst_busy", {63'd0, busy}, 64'd0);
    check_value("rst_done", {63'd0, done}, 64'd0);
    check_value("rst_hi", {32'd0, hi}, 64'd0);
    check_value("rst_lo", {32'd0, lo}, 64'd0);
    check_value("rst_dz", {63'd0, divZero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b0);
`ifdef MULDIV_DIVIDER_EN
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 1'b0);
    run_op(2'b10, 32'd5, 32'd0, 32'h0000_0000, 32'h8000_0000, 1'b1, 0, 1'b0);
`else
    run_op(2'b11, 32'd100, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 1'b0);
    run_op(2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 1'b0);
`endif
    run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, 1'b0);

    // Abort a running multiply with reset: no done, everything back to reset values
    start = 1'b1;
    op    = 2'b01;
    regA  = 32'd5;
    regB  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_value("abort_busy", {63'd0, busy}, 64'd0);
    check_value("abort_done", {63'd0, done}, 64'd0);
    check_value("abort_hi", {32'd0, hi}, 64'd0);
    check_value("abort_lo", {32'd0, lo}, 64'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    repeat (40) @(negedge clk);
    run_op(2'b01, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0, 33, 1'b0);

    // start pulsed while busy must be ignored
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1);
    do_op(2'b10, 32'h8765_4321, 32'h0000_0013, 1'b1);
    for (int i = 0; i < 10; i++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      o = 2'($urandom_range(3, 0));
      a = $urandom;
      b = (i == 3) ? 32'd0 : $urandom;
      if (i == 6) b = 32'hFFFF_FFFF;
      do_op(o, a, b, (i % 4) == 1);
    end

    repeat (5) @(negedge clk);
    check_value("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
